// File: rtl/hilo_unit.sv
// HI/LO sequencing stage for the MULT32 multiplier: latches operands, waits a fixed
// settle interval, captures HI/LO, and services direct HI/LO writes and stalled reads.
module hilo_unit #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] OP_A,
  input  logic [31:0] OP_B,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] MUL_A,
  output logic [31:0] MUL_B,
  input  logic [31:0] MUL_HI,
  input  logic [31:0] MUL_LO,
  input  logic        WR_HI,
  input  logic        WR_LO,
  input  logic [31:0] WR_DATA,
  input  logic        RD_REQ,
  input  logic        RD_SEL,
  output logic [31:0] RD_DATA,
  output logic        STALL
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic [31:0] opa_reg;
  logic [31:0] opb_reg;
  logic        busy_reg;
  logic        done_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      opa_reg  <= '0;
      opb_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          // Direct writes only land while idle; a write alongside START still
          // takes effect and is later overwritten by the capture.
          if (WR_HI) hi_reg <= WR_DATA;
          if (WR_LO) lo_reg <= WR_DATA;
          if (START) begin
            opa_reg  <= OP_A;
            opb_reg  <= OP_B;
            cnt      <= CNT_INIT;
            busy_reg <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            hi_reg   <= MUL_HI;
            lo_reg   <= MUL_LO;
            done_reg <= 1'b1;
            busy_reg <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign BUSY    = busy_reg;
  assign DONE    = done_reg;
  assign MUL_A   = opa_reg;
  assign MUL_B   = opb_reg;
  assign RD_DATA = RD_SEL ? hi_reg : lo_reg;
  assign STALL   = RD_REQ & busy_reg;

endmodule
